// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   RV32 integer register file: 2**ADDR_WIDTH entries of DATA_WIDTH bits, two
//   combinational read ports (rs1/rs2) and one synchronous write port (rd).
//   Entry 0 always reads zero. When BYPASS=1, a read of the address being
//   written in the current cycle returns wdata before the clock edge.
//
// Ports
//   clk     in   1           clock; writes happen on the rising edge
//   rst     in   1           asynchronous, active-low reset (clears all entries)
//   we      in   1           write enable
//   waddr   in   ADDR_WIDTH  write address (rd)
//   wdata   in   DATA_WIDTH  write data
//   raddr1  in   ADDR_WIDTH  read address, port 1 (rs1)
//   raddr2  in   ADDR_WIDTH  read address, port 2 (rs2)
//   rdata1  out  DATA_WIDTH  read data, port 1
//   rdata2  out  DATA_WIDTH  read data, port 2
//
// Handshake: there is none. A write is accepted at every rising edge where
//   rst is high, we is high and waddr is non-zero; reads are pure functions of
//   the current addresses, stored state and (with BYPASS) the pending write.
// -----------------------------------------------------------------------------
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    // A write is only real when enabled and not aimed at x0. Evaluating we
    // first keeps an unknown waddr harmless while we is low.
    logic wr_en;
    assign wr_en = we && (waddr != '0);

    // Entry 0 is cleared by reset and never written afterwards; reads of
    // address 0 are masked below regardless of what it holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Bypass is gated by rst so that nothing but zero is visible while the
    // file is held in reset, even with a write pending on the inputs.
    logic byp1;
    logic byp2;
    assign byp1 = (BYPASS != 0) && rst && wr_en && (waddr == raddr1);
    assign byp2 = (BYPASS != 0) && rst && wr_en && (waddr == raddr2);

    always_comb begin
        rdata1 = '0;
        if (rst && (raddr1 != '0)) begin
            if (byp1) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst && (raddr2 != '0)) begin
            if (byp2) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//   Self-checking bench for register_file. Two instances share one set of
//   inputs: dut_byp (BYPASS=1) and dut_nob (BYPASS=0). Expected read data comes
//   from a plain array model of the architectural registers.
// -----------------------------------------------------------------------------
module tb_register_file;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          we     = 1'b0;
    logic [AW-1:0] waddr  = '0;
    logic [DW-1:0] wdata  = '0;
    logic [AW-1:0] raddr1 = '0;
    logic [AW-1:0] raddr2 = '0;

    logic [DW-1:0] b_rdata1, b_rdata2;
    logic [DW-1:0] n_rdata1, n_rdata2;

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(b_rdata1), .rdata2(b_rdata2)
    );

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(0)) dut_nob (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(n_rdata1), .rdata2(n_rdata2)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] model_mem [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q [$];

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // Architectural view: x0 is zero, reset reads zero, and with bypass a
    // pending legal write to the same address is visible immediately.
    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input bit byp);
        if (!rst) return '0;
        if (a == 0) return '0;
        if (byp && we && (waddr == a)) return wdata;
        return model_mem[a];
    endfunction

    // Called right after a rising edge to mirror what that edge committed.
    task automatic model_edge(input logic r, input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
        if (r && w && (a != 0)) model_mem[a] = d;
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: queue the four expectations, then pop them against the
    // four observed outputs in the same order.
    task automatic check_ports(input string tag);
        exp_q.push_back(model_read(raddr1, 1'b1));
        exp_q.push_back(model_read(raddr2, 1'b1));
        exp_q.push_back(model_read(raddr1, 1'b0));
        exp_q.push_back(model_read(raddr2, 1'b0));
        check_eq({tag, ".byp.rd1"}, b_rdata1, exp_q.pop_front());
        check_eq({tag, ".byp.rd2"}, b_rdata2, exp_q.pop_front());
        check_eq({tag, ".nob.rd1"}, n_rdata1, exp_q.pop_front());
        check_eq({tag, ".nob.rd2"}, n_rdata2, exp_q.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk);
        model_edge(rst, 1'b1, a, d);
        #1;
        we = 1'b0;
    endtask

    task automatic scan_all(input string tag);
        we = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            raddr1 = AW'(a);
            raddr2 = AW'(DEPTH - 1 - a);
            #1;
            check_ports($sformatf("%s[%0d]", tag, a));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_clear();

        // 1. reset held, then released
        repeat (2) @(posedge clk);
        raddr1 = 5'd5; raddr2 = 5'd31; #1;
        check_ports("in_reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        scan_all("after_reset");

        // 2. two writes, then read back and confirm nothing else moved
        do_write(5'd5,  32'hDEADBEEF);
        do_write(5'd31, 32'h12345678);
        @(negedge clk);
        raddr1 = 5'd5; raddr2 = 5'd31; #1;
        check_eq("x5_direct",  b_rdata1, 32'hDEADBEEF);
        check_eq("x31_direct", b_rdata2, 32'h12345678);
        scan_all("after_two_writes");

        // 3. write to x0 is dropped, both before and after the edge
        @(negedge clk);
        we = 1'b1; waddr = '0; wdata = 32'hFFFFFFFF; raddr1 = '0; raddr2 = '0;
        #1;
        check_ports("x0_pre_edge");
        check_eq("x0_pre_byp", b_rdata1, 32'h0);
        @(posedge clk);
        model_edge(rst, we, waddr, wdata);
        #1;
        check_ports("x0_post_edge");
        we = 1'b0;
        scan_all("after_x0_write");

        // 4. bypass vs. no bypass on a same-cycle write
        do_write(5'd7, 32'h1);
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'hCAFEF00D; raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        check_eq("byp_pre_edge",   b_rdata1, 32'hCAFEF00D);
        check_eq("nobyp_pre_edge", n_rdata1, 32'h1);
        check_ports("x7_pre_edge");
        @(posedge clk);
        model_edge(rst, we, waddr, wdata);
        #1;
        we = 1'b0; #1;
        check_eq("byp_post_edge",   b_rdata1, 32'hCAFEF00D);
        check_eq("nobyp_post_edge", n_rdata1, 32'hCAFEF00D);
        check_ports("x7_post_edge");

        // 5. reset asserted mid-cycle during a write wins
        do_write(5'd3, 32'hAAAA5555);
        @(posedge clk);
        #2;
        rst = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'h5A5A5A5A;
        raddr1 = 5'd3; raddr2 = 5'd5;
        model_clear();
        #1;
        check_eq("rst_x3_immediate", b_rdata1, 32'h0);
        check_ports("rst_immediate");
        @(posedge clk); #1;
        check_ports("rst_held_edge");
        @(negedge clk);
        rst = 1'b1; we = 1'b0;
        @(posedge clk); #1;
        check_eq("x3_after_rst_idle", n_rdata1, 32'h0);
        check_ports("rst_released");
        do_write(5'd3, 32'h0BADF00D);
        #1;
        check_eq("first_write_after_rst", n_rdata1, 32'h0BADF00D);
        scan_all("after_rst_test");

        // 6. randomized traffic
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            we     = 1'($urandom_range(0, 1));
            waddr  = AW'($urandom_range(0, DEPTH - 1));
            wdata  = $urandom;
            raddr1 = AW'($urandom_range(0, DEPTH - 1));
            raddr2 = AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 3) == 0) raddr1 = waddr;
            if ($urandom_range(0, 3) == 0) raddr2 = raddr1;
            if ($urandom_range(0, 7) == 0) waddr = 5'd0;
            if (!we && $urandom_range(0, 15) == 0) waddr = 'x;
            #1;
            check_ports($sformatf("rand%0d", cyc));
            @(posedge clk);
            model_edge(rst, we, waddr, wdata);
        end
        @(negedge clk);
        scan_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends on its own.
    initial begin
        #500000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
